// File: rtl/wishbone_dma_pkg.sv
// Shared types and constants for the Wishbone DMA copy engine.
package wishbone_dma_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RD_GAP = 3'd2,
        WR     = 3'd3,
        WR_GAP = 3'd4
    } dma_state_e;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        BUS_ERR = 2'd1,
        TIMEOUT = 2'd2,
        ABORTED = 2'd3
    } dma_status_e;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/wishbone_dma_if.sv
// Classic Wishbone bus bundle shared by the DMA initiator and its slaves.
interface wishbone_interface;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_mosi;
    logic [31:0] dat_miso;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, adr, sel, dat_mosi,
        input  dat_miso, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_mosi,
        output dat_miso, ack, err
    );
endinterface

// File: rtl/wishbone_dma.sv
// Word-by-word memory copy engine: read one word from the source region,
// write it to the destination region, repeat LEN times. Every ack/err is
// followed by one cycle with stb low so a slave never sees a stale request.
module wishbone_dma
    import wishbone_dma_pkg::*;
#(
    parameter int          LEN_W    = 16,
    parameter logic [31:0] ADR_STEP = 32'd4,
    parameter int          TIMEOUT  = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [LEN_W-1:0] words_done,
    output logic [31:0]      fault_addr,
    wishbone_interface.master wishbone
);

    // The counter only needs to reach TIMEOUT-1; the terminal compare fires there.
    localparam int             TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    dma_state_e       state_reg, state_next;
    dma_status_e      status_reg, status_next;
    logic [31:0]      src_reg, src_next;
    logic [31:0]      dst_reg, dst_next;
    logic [LEN_W-1:0] rem_reg, rem_next;
    logic [LEN_W-1:0] words_done_reg, words_done_next;
    logic [31:0]      data_reg, data_next;
    logic [31:0]      fault_addr_reg, fault_addr_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             cyc_reg, cyc_next;
    logic             stb_reg, stb_next;
    logic             we_reg, we_next;
    logic [31:0]      adr_reg, adr_next;
    logic [3:0]       sel_reg, sel_next;
    logic [31:0]      dat_mosi_reg, dat_mosi_next;

    // Job termination request collected by the FSM, applied in one place.
    logic             end_job;
    dma_status_e      end_status;
    logic             record_fault;
    logic             timed_out;

    assign timed_out = (TIMEOUT != 0) && (to_cnt_reg == TO_LAST);

    // State and datapath registers; async reset releases the bus at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            status_reg     <= OK;
            src_reg        <= '0;
            dst_reg        <= '0;
            rem_reg        <= '0;
            words_done_reg <= '0;
            data_reg       <= '0;
            fault_addr_reg <= '0;
            to_cnt_reg     <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            cyc_reg        <= 1'b0;
            stb_reg        <= 1'b0;
            we_reg         <= 1'b0;
            adr_reg        <= '0;
            sel_reg        <= '0;
            dat_mosi_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            status_reg     <= status_next;
            src_reg        <= src_next;
            dst_reg        <= dst_next;
            rem_reg        <= rem_next;
            words_done_reg <= words_done_next;
            data_reg       <= data_next;
            fault_addr_reg <= fault_addr_next;
            to_cnt_reg     <= to_cnt_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            cyc_reg        <= cyc_next;
            stb_reg        <= stb_next;
            we_reg         <= we_next;
            adr_reg        <= adr_next;
            sel_reg        <= sel_next;
            dat_mosi_reg   <= dat_mosi_next;
        end
    end

    // Next-state and next-output logic; priority is abort > err > ack > timeout.
    always_comb begin
        state_next      = state_reg;
        status_next     = status_reg;
        src_next        = src_reg;
        dst_next        = dst_reg;
        rem_next        = rem_reg;
        words_done_next = words_done_reg;
        data_next       = data_reg;
        fault_addr_next = fault_addr_reg;
        to_cnt_next     = to_cnt_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        cyc_next        = cyc_reg;
        stb_next        = stb_reg;
        we_next         = we_reg;
        adr_next        = adr_reg;
        sel_next        = sel_reg;
        dat_mosi_next   = dat_mosi_reg;
        end_job         = 1'b0;
        end_status      = OK;
        record_fault    = 1'b0;

        if (state_reg != IDLE && abort) begin
            end_job    = 1'b1;
            end_status = ABORTED;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        words_done_next = '0;
                        if (length != '0) begin
                            src_next    = src_addr;
                            dst_next    = dst_addr;
                            rem_next    = length;
                            busy_next   = 1'b1;
                            cyc_next    = 1'b1;
                            stb_next    = 1'b1;
                            we_next     = 1'b0;
                            adr_next    = src_addr;
                            sel_next    = WB_SEL_ALL;
                            to_cnt_next = '0;
                            state_next  = RD;
                        end else begin
                            done_next   = 1'b1;
                            status_next = OK;
                        end
                    end
                end
                RD: begin
                    if (wishbone.err) begin
                        end_job      = 1'b1;
                        end_status   = BUS_ERR;
                        record_fault = 1'b1;
                    end else if (wishbone.ack) begin
                        data_next  = wishbone.dat_miso;
                        stb_next   = 1'b0;
                        state_next = RD_GAP;
                    end else if (timed_out) begin
                        end_job      = 1'b1;
                        end_status   = wishbone_dma_pkg::TIMEOUT;
                        record_fault = 1'b1;
                    end else begin
                        to_cnt_next = to_cnt_reg + TO_W'(1);
                    end
                end
                RD_GAP: begin
                    stb_next      = 1'b1;
                    we_next       = 1'b1;
                    adr_next      = dst_reg;
                    dat_mosi_next = data_reg;
                    to_cnt_next   = '0;
                    state_next    = WR;
                end
                WR: begin
                    if (wishbone.err) begin
                        end_job      = 1'b1;
                        end_status   = BUS_ERR;
                        record_fault = 1'b1;
                    end else if (wishbone.ack) begin
                        stb_next        = 1'b0;
                        we_next         = 1'b0;
                        dat_mosi_next   = '0;
                        words_done_next = words_done_reg + LEN_W'(1);
                        rem_next        = rem_reg - LEN_W'(1);
                        src_next        = src_reg + ADR_STEP;
                        dst_next        = dst_reg + ADR_STEP;
                        if (rem_reg == LEN_W'(1)) begin
                            end_job    = 1'b1;
                            end_status = OK;
                        end else begin
                            state_next = WR_GAP;
                        end
                    end else if (timed_out) begin
                        end_job      = 1'b1;
                        end_status   = wishbone_dma_pkg::TIMEOUT;
                        record_fault = 1'b1;
                    end else begin
                        to_cnt_next = to_cnt_reg + TO_W'(1);
                    end
                end
                WR_GAP: begin
                    stb_next    = 1'b1;
                    we_next     = 1'b0;
                    adr_next    = src_reg;
                    to_cnt_next = '0;
                    state_next  = RD;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        if (end_job) begin
            cyc_next      = 1'b0;
            stb_next      = 1'b0;
            we_next       = 1'b0;
            dat_mosi_next = '0;
            busy_next     = 1'b0;
            done_next     = 1'b1;
            status_next   = end_status;
            state_next    = IDLE;
            if (record_fault) begin
                fault_addr_next = adr_reg;
            end
        end
    end

    assign busy              = busy_reg;
    assign done              = done_reg;
    assign status            = status_reg;
    assign words_done        = words_done_reg;
    assign fault_addr        = fault_addr_reg;
    assign wishbone.cyc      = cyc_reg;
    assign wishbone.stb      = stb_reg;
    assign wishbone.we       = we_reg;
    assign wishbone.adr      = adr_reg;
    assign wishbone.sel      = sel_reg;
    assign wishbone.dat_mosi = dat_mosi_reg;

endmodule

// File: tb/tb_wishbone_dma.sv
// Bench for wishbone_dma: RAM + LED + silent stub slave, write scoreboard,
// completion scoreboard and stb-gap monitor.
module tb_wishbone_dma;
    import wishbone_dma_pkg::*;

    localparam int          LEN_W    = 16;
    localparam int          TO_CYC   = 8;
    localparam logic [31:0] LED_ADR  = 32'h8000_0000;
    localparam logic [31:0] STUB_ADR = 32'h9000_0000;
    localparam logic [31:0] RAM_TOP  = 32'h0000_1000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] length = '0;
    logic             busy;
    logic             done;
    logic [1:0]       status;
    logic [LEN_W-1:0] words_done;
    logic [31:0]      fault_addr;

    wishbone_interface wb();

    wishbone_dma #(.LEN_W(LEN_W), .ADR_STEP(32'd4), .TIMEOUT(TO_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .words_done (words_done),
        .fault_addr (fault_addr),
        .wishbone   (wb.master)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- slave models ----------------
    logic [31:0] ram [0:1023];
    logic [15:0] led_reg;

    always @(posedge clk) begin
        wb.ack <= 1'b0;
        wb.err <= 1'b0;
        if (wb.cyc && wb.stb && !wb.ack && !wb.err) begin
            if (wb.adr == LED_ADR) begin
                wb.ack <= 1'b1;
                if (wb.we) led_reg <= wb.dat_mosi[15:0];
                else       wb.dat_miso <= {16'h0000, led_reg};
            end else if (wb.adr == STUB_ADR) begin
                wb.ack <= 1'b0;
            end else if (wb.adr < RAM_TOP) begin
                wb.ack <= 1'b1;
                if (wb.we) ram[wb.adr[11:2]] <= wb.dat_mosi;
                else       wb.dat_miso <= ram[wb.adr[11:2]];
            end else begin
                wb.err <= 1'b1;
            end
        end
    end

    // ---------------- write scoreboard ----------------
    typedef struct { logic [31:0] adr; logic [31:0] dat; } wr_t;
    wr_t wr_q[$];

    always @(negedge clk) begin
        wr_t e;
        if (wb.cyc && wb.ack) begin
            if (wb.we) begin
                $display("[%0t] WR adr=%08h dat=%08h", $time, wb.adr, wb.dat_mosi);
                chk("wr_sel", {60'd0, wb.sel}, 64'hF);
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 64'd1, 64'd0);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_adr", {32'd0, wb.adr}, {32'd0, e.adr});
                    chk("wr_dat", {32'd0, wb.dat_mosi}, {32'd0, e.dat});
                end
            end else begin
                $display("[%0t] RD adr=%08h dat=%08h", $time, wb.adr, wb.dat_miso);
            end
        end else if (wb.cyc && wb.err) begin
            $display("[%0t] ERR adr=%08h we=%0b", $time, wb.adr, wb.we);
        end
    end

    // ---------------- stb gap monitor ----------------
    int  gap = 0;
    bit  in_job = 1'b0;

    always @(negedge clk) begin
        if (!wb.cyc) begin
            in_job = 1'b0;
            gap = 0;
        end else begin
            if (in_job && wb.stb && gap != 0) begin
                chk("stb_gap", 64'(gap), 64'd1);
                gap = 0;
            end else if (!wb.stb) begin
                gap++;
            end
            in_job = 1'b1;
        end
    end

    // ---------------- completion scoreboard ----------------
    typedef struct { logic [1:0] st; logic [15:0] wd; logic [31:0] fa; int lat; } exp_t;
    exp_t done_q[$];

    task automatic run_job(input string name, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input logic [1:0] est, input logic [15:0] ewd,
                           input logic [31:0] efa, input int elat);
        exp_t e;
        int   lat = 0;
        bit   seen = 1'b0;
        bit   saw_busy = 1'b0;
        bit   saw_cyc = 1'b0;
        e.st = est; e.wd = ewd; e.fa = efa; e.lat = elat;
        done_q.push_back(e);
        @(negedge clk);
        src_addr = s; dst_addr = d; length = n; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
            if (wb.cyc) saw_cyc = 1'b1;
            if (done) begin
                lat = i;
                seen = 1'b1;
                break;
            end
        end
        $display("[%0t] JOB %s len=%0d status=%0d words=%0d fault=%08h lat=%0d",
                 $time, name, n, status, words_done, fault_addr, lat);
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
        e = done_q.pop_front();
        if (seen) begin
            chk({name, "_status"}, {62'd0, status}, {62'd0, e.st});
            chk({name, "_words"}, {48'd0, words_done}, {48'd0, e.wd});
            chk({name, "_latency"}, 64'(lat), 64'(e.lat));
            chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
            chk({name, "_cyc_at_done"}, 64'(wb.cyc), 64'd0);
            if (e.st == BUS_ERR || e.st == TIMEOUT)
                chk({name, "_fault"}, {32'd0, fault_addr}, {32'd0, e.fa});
        end
        chk({name, "_busy_seen"}, 64'(saw_busy), 64'(n != 0));
        chk({name, "_cyc_seen"}, 64'(saw_cyc), 64'(n != 0));
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        wr_t w;
        for (int k = 0; k < n; k++) begin
            w.adr = d + 32'(4 * k);
            w.dat = (s == LED_ADR) ? {16'h0000, led_reg} : ram[(s >> 2) + 32'(k)];
            wr_q.push_back(w);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'hDEAD_0000 | 32'(i);
        for (int i = 0; i < 4; i++) ram[i] = 32'(i + 1);
        led_reg = 16'hA5C3;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 64'(wb.cyc), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_status", {62'd0, status}, 64'd0);
        chk("rst_words", {48'd0, words_done}, 64'd0);
        chk("rst_adr", {32'd0, wb.adr}, 64'd0);
        @(negedge clk) rst = 1'b1;

        // 1: LED -> RAM
        push_copy(LED_ADR, 32'h100, 1);
        run_job("led", LED_ADR, 32'h100, 16'd1, OK, 16'd1, 32'h0, 6);
        chk("led_ram", {32'd0, ram[32'h100 >> 2]}, 64'h0000_A5C3);

        // 2: four words RAM -> RAM
        push_copy(32'h0, 32'h40, 4);
        run_job("copy4", 32'h0, 32'h40, 16'd4, OK, 16'd4, 32'h0, 24);
        for (int k = 0; k < 4; k++)
            chk("copy4_ram", {32'd0, ram[16 + k]}, 64'(k + 1));

        // 3: third write falls off the RAM
        push_copy(32'h200, 32'hFF8, 2);
        run_job("buserr", 32'h200, 32'hFF8, 16'd3, BUS_ERR, 16'd2, 32'h1000, 18);

        // 4: silent slave
        run_job("tmo", STUB_ADR, 32'h100, 16'd1, TIMEOUT, 16'd0, STUB_ADR, 9);

        // 5: abort coincident with the 3rd write ack, plus start while busy
        push_copy(32'h400, 32'h600, 3);
        fork
            run_job("abort", 32'h400, 32'h600, 16'd10, ABORTED, 16'd2, 32'h0, 18);
            begin
                int wr_acks = 0;
                bit hit = 1'b0;
                for (int i = 0; i < 300 && !hit; i++) begin
                    @(negedge clk);
                    if (i == 10) begin
                        start = 1'b1; src_addr = 32'h300; dst_addr = 32'h380; length = 16'd1;
                    end
                    if (i == 11) start = 1'b0;
                    if (wb.ack && wb.we) begin
                        wr_acks++;
                        if (wr_acks == 3) begin
                            abort = 1'b1;
                            hit = 1'b1;
                        end
                    end
                end
                @(posedge clk);
                #1 abort = 1'b0;
            end
        join
        chk("ignored_start_ram", {32'd0, ram[32'h380 >> 2]}, {32'd0, 32'hDEAD_0000 | 32'(32'h380 >> 2)});

        // 6a: zero length
        run_job("len0", 32'h0, 32'h80, 16'd0, OK, 16'd0, 32'h0, 1);

        // 6b: async reset in the middle of a read
        @(negedge clk);
        src_addr = STUB_ADR; dst_addr = 32'h100; length = 16'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3;
        chk("prerst_cyc", 64'(wb.cyc), 64'd1);
        rst = 1'b0;
        #1;
        chk("arst_cyc", 64'(wb.cyc), 64'd0);
        chk("arst_stb", 64'(wb.stb), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_status", {62'd0, status}, 64'd0);
        chk("arst_words", {48'd0, words_done}, 64'd0);
        chk("arst_fault", {32'd0, fault_addr}, 64'd0);
        chk("arst_adr", {32'd0, wb.adr}, 64'd0);
        chk("arst_sel", {60'd0, wb.sel}, 64'd0);
        @(negedge clk) rst = 1'b1;

        // recovery after reset
        push_copy(32'h8, 32'h500, 1);
        run_job("recover", 32'h8, 32'h500, 16'd1, OK, 16'd1, 32'h0, 6);

        chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wishbone_dma.md
Name: wishbone_dma

Overview:
Wishbone initiator that copies LEN 32-bit words from a source region to a destination region, one word at a time: a read from the source, then a write to the destination. It drives the existing peripheral slaves, such as LEDs and memory, over the system Wishbone bus. A simple start/done sideband from the core or test logic controls it. It reports bus errors, timeouts and aborts, and records the faulting address.

Parameters:
LEN_W, 16, width of the length and words_done fields.
ADR_STEP, 32'd4, address increment per word for both regions.
TIMEOUT, 256, maximum cycles stb may stay high without ack/err; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  single-cycle job request; sampled only in IDLE
abort  in  1  terminate the running job
src_addr  in  32  first source address; captured on an accepted start
dst_addr  in  32  first destination address; captured on an accepted start
length  in  LEN_W  number of words; captured on an accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
status  out  2  result of the last job: 0 OK, 1 BUS_ERR, 2 TIMEOUT, 3 ABORTED
words_done  out  LEN_W  count of completed word writes in the current/last job
fault_addr  out  32  address on the bus when BUS_ERR or TIMEOUT occurred
wishbone  wishbone_interface.master  cyc, stb, we, adr, sel, dat_mosi driven; dat_miso, ack, err sampled

Behaviour:
- Reset (rst=0, async): state IDLE; cyc, stb, we, busy, done = 0; adr, sel, dat_mosi = 0; status = OK; words_done = 0; fault_addr = 0. If reset hits mid-transfer, the bus is released immediately.
- All outputs are registered. done defaults to 0 every cycle.
- FSM states: IDLE, RD, RD_GAP, WR, WR_GAP.
- IDLE:
  - On start with length != 0: latch the addresses and the remaining count, clear words_done, set busy=1, cyc=1, stb=1, we=0, adr=src, sel=4'hF, and go to RD.
  - On start with length == 0: done=1 with status=OK the next cycle; no bus activity and busy stays 0.
- RD: hold stb, adr and we stable until ack or err.
  - On ack: capture dat_miso into the data register, stb=0, go to RD_GAP.
- RD_GAP: stb low for exactly one cycle, cyc held. Then stb=1, we=1, adr=dst, dat_mosi=data, go to WR.
- WR: on ack, stb=0, we=0, dat_mosi=0, words_done+1, remaining-1, src+=ADR_STEP, dst+=ADR_STEP (wrap mod 2^32).
  - If remaining was 1: cyc=0, busy=0, done=1, status=OK, go to IDLE.
  - Otherwise go to WR_GAP.
- WR_GAP: one cycle with stb low, then stb=1, we=0, adr=src, go to RD.
- The one-cycle stb-low gap after every ack is mandatory, so a slave cannot see a stale request.
- err while stb=1: status=BUS_ERR, fault_addr=current adr, release the bus (cyc=stb=we=0), busy=0, done=1, go to IDLE. If err and ack arrive in the same cycle, err wins.
- Timeout: a counter clears whenever stb rises and counts each cycle stb=1 with no ack/err.
  - On reaching TIMEOUT (when TIMEOUT != 0): status=TIMEOUT, fault_addr=adr, release the bus, done=1, go to IDLE.
- abort during any busy cycle: release the bus next edge, status=ABORTED, done=1, go to IDLE. abort beats a same-cycle ack or err; that word is not counted.
- Ignored inputs: start while busy is ignored. abort in IDLE is ignored.
- Latency with a 1-cycle-ack slave: 6 cycles per word. If start is sampled at edge E0, done is high in the cycle after edge E0+6N-1.

Decomposition:
- Package wishbone_dma_pkg holds:
  - dma_state_e enum {IDLE, RD, RD_GAP, WR, WR_GAP}
  - dma_status_e enum {OK=0, BUS_ERR=1, TIMEOUT=2, ABORTED=3}
  - constant WB_SEL_ALL=4'hF
- Single module, no sub-module; the timeout counter is inline.

Test Plan:
1. Copy from the LED slave: LEDs pre-written 16'hA5C3, src=LED addr, dst=RAM 0x100, length=1 → RAM[0x100]=32'h0000A5C3, done in cycle E0+6, status=OK, words_done=1.
2. length=4, src=0x00, dst=0x40, RAM src = 1,2,3,4 → RAM[0x40..0x4C] = 1..4, stb low exactly 1 cycle after each ack, done at E0+24, words_done=4.
3. length=3, dst range starts inside the valid region, 3rd write address outside the slave region → slave err; status=BUS_ERR, fault_addr=dst+8, words_done=2, cyc=0 next cycle.
4. TIMEOUT=8, src at an address with a never-responding stub → done after stb held 8 cycles, status=TIMEOUT, fault_addr=src.
5. length=10, abort asserted in the 3rd word's WR cycle, coincident with ack → status=ABORTED, words_done=2, bus idle next cycle. start during busy has no effect.
6. length=0 start → done=1 next cycle, busy never 1, no cyc. Async rst=0 mid-RD → cyc/stb drop without a clock edge, all outputs at reset values.
